// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Registered, parameterised ALU with an arithmetic command set (MODE=1)
//   and a logical command set (MODE=0). Most commands complete in a single
//   cycle. The two multiply commands take a 3-cycle pipeline. A two-operand
//   command that arrives with only one operand valid waits up to 15 further
//   edges for both operands, then times out with ERR.
//
//   Every input is registered on the edge that samples it. The FSM acts on
//   those registered copies at the following edge. A result is therefore
//   visible one edge after its inputs were sampled, and a multiply result
//   three edges after.
//
// Ports
//   CLK        clock, everything on the rising edge
//   RST        synchronous active-high reset (priority over CE)
//   OPA, OPB   operands (WIDTH)
//   CMD        command code (CWIDTH)
//   MODE       1 = arithmetic, 0 = logical
//   CIN        carry-in, used by ADD_CIN / SUB_CIN only
//   CE         clock enable; 0 clears outputs and aborts pending work
//   INP_VALID  bit0 = OPA valid, bit1 = OPB valid
//   RES        result, zero-extended to 2*WIDTH
//   COUT       carry / borrow out
//   OFLOW      overflow
//   E, G, L    compare flags (CMP only)
//   ERR        error
// ---------------------------------------------------------------------------
module alu_core #(
    parameter int WIDTH  = 8,
    parameter int CWIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    input  logic [CWIDTH-1:0]    CMD,
    input  logic                 MODE,
    input  logic                 CIN,
    input  logic                 CE,
    input  logic [1:0]           INP_VALID,
    output logic [2*WIDTH-1:0]   RES,
    output logic                 COUT,
    output logic                 OFLOW,
    output logic                 E,
    output logic                 G,
    output logic                 L,
    output logic                 ERR
);

    localparam int RW = 2 * WIDTH;       // result width
    localparam int MW = WIDTH + 1;       // multiplier operand width
    localparam int SH = $clog2(WIDTH);   // rotate-amount width

    // Arithmetic command codes
    localparam logic [CWIDTH-1:0] A_ADD     = CWIDTH'(4'd0);
    localparam logic [CWIDTH-1:0] A_SUB     = CWIDTH'(4'd1);
    localparam logic [CWIDTH-1:0] A_ADD_CIN = CWIDTH'(4'd2);
    localparam logic [CWIDTH-1:0] A_SUB_CIN = CWIDTH'(4'd3);
    localparam logic [CWIDTH-1:0] A_INC_A   = CWIDTH'(4'd4);
    localparam logic [CWIDTH-1:0] A_DEC_A   = CWIDTH'(4'd5);
    localparam logic [CWIDTH-1:0] A_INC_B   = CWIDTH'(4'd6);
    localparam logic [CWIDTH-1:0] A_DEC_B   = CWIDTH'(4'd7);
    localparam logic [CWIDTH-1:0] A_CMP     = CWIDTH'(4'd8);
    localparam logic [CWIDTH-1:0] A_MUL_INC = CWIDTH'(4'd9);
    localparam logic [CWIDTH-1:0] A_MUL_SHL = CWIDTH'(4'd10);

    // Logical command codes
    localparam logic [CWIDTH-1:0] L_AND     = CWIDTH'(4'd0);
    localparam logic [CWIDTH-1:0] L_NAND    = CWIDTH'(4'd1);
    localparam logic [CWIDTH-1:0] L_OR      = CWIDTH'(4'd2);
    localparam logic [CWIDTH-1:0] L_NOR     = CWIDTH'(4'd3);
    localparam logic [CWIDTH-1:0] L_XOR     = CWIDTH'(4'd4);
    localparam logic [CWIDTH-1:0] L_XNOR    = CWIDTH'(4'd5);
    localparam logic [CWIDTH-1:0] L_NOT_A   = CWIDTH'(4'd6);
    localparam logic [CWIDTH-1:0] L_NOT_B   = CWIDTH'(4'd7);
    localparam logic [CWIDTH-1:0] L_SHR1_A  = CWIDTH'(4'd8);
    localparam logic [CWIDTH-1:0] L_SHL1_A  = CWIDTH'(4'd9);
    localparam logic [CWIDTH-1:0] L_SHR1_B  = CWIDTH'(4'd10);
    localparam logic [CWIDTH-1:0] L_SHL1_B  = CWIDTH'(4'd11);
    localparam logic [CWIDTH-1:0] L_ROL_A_B = CWIDTH'(4'd12);
    localparam logic [CWIDTH-1:0] L_ROR_A_B = CWIDTH'(4'd13);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_OP = 2'd1,
        S_MUL1    = 2'd2,
        S_MUL2    = 2'd3
    } state_t;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          cout;
        logic          oflow;
        logic          e;
        logic          g;
        logic          l;
        logic          err;
    } out_t;

    // ------------------------------------------------------------------
    // Command classification helpers
    // ------------------------------------------------------------------
    function automatic logic cmd_ok(input logic mode, input logic [CWIDTH-1:0] cmd);
        logic ok;
        if (mode) begin
            ok = (cmd <= A_MUL_SHL);
        end else begin
            ok = (cmd <= L_ROR_A_B);
        end
        return ok;
    endfunction

    // Required valid bits: 2'b01 = A only, 2'b10 = B only, 2'b11 = both.
    function automatic logic [1:0] need_mask(input logic mode, input logic [CWIDTH-1:0] cmd);
        logic [1:0] m;
        m = 2'b11;
        if (mode) begin
            case (cmd)
                A_INC_A, A_DEC_A: m = 2'b01;
                A_INC_B, A_DEC_B: m = 2'b10;
                default:          m = 2'b11;
            endcase
        end else begin
            case (cmd)
                L_NOT_A, L_SHR1_A, L_SHL1_A: m = 2'b01;
                L_NOT_B, L_SHR1_B, L_SHL1_B: m = 2'b10;
                default:                     m = 2'b11;
            endcase
        end
        return m;
    endfunction

    function automatic logic is_mul(input logic mode, input logic [CWIDTH-1:0] cmd);
        return mode && ((cmd == A_MUL_INC) || (cmd == A_MUL_SHL));
    endfunction

    function automatic out_t err_result();
        out_t o;
        o     = '0;
        o.err = 1'b1;
        return o;
    endfunction

    // Single-cycle datapath. Multiply codes return zero here; the pipeline
    // supplies their result.
    function automatic out_t compute(input logic              mode,
                                     input logic [CWIDTH-1:0] cmd,
                                     input logic              cin,
                                     input logic [WIDTH-1:0]  a,
                                     input logic [WIDTH-1:0]  b);
        out_t             o;
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] narrow;
        logic [RW-1:0]    rot;
        o      = '0;
        wide   = '0;
        narrow = '0;
        rot    = '0;
        if (mode) begin
            case (cmd)
                A_ADD: begin
                    wide    = {1'b0, a} + {1'b0, b};
                    o.res   = RW'(wide);
                    o.cout  = wide[WIDTH];
                end
                A_ADD_CIN: begin
                    wide    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                    o.res   = RW'(wide);
                    o.cout  = wide[WIDTH];
                end
                // Difference kept to WIDTH bits; bit WIDTH of the extended
                // subtraction is the borrow.
                A_SUB: begin
                    wide    = {1'b0, a} - {1'b0, b};
                    o.res   = RW'(wide[WIDTH-1:0]);
                    o.cout  = wide[WIDTH];
                    o.oflow = wide[WIDTH];
                end
                A_SUB_CIN: begin
                    wide    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
                    o.res   = RW'(wide[WIDTH-1:0]);
                    o.cout  = wide[WIDTH];
                    o.oflow = wide[WIDTH];
                end
                A_INC_A: begin
                    narrow  = a + {{(WIDTH-1){1'b0}}, 1'b1};
                    o.res   = RW'(narrow);
                    o.oflow = &a;
                end
                A_DEC_A: begin
                    narrow  = a - {{(WIDTH-1){1'b0}}, 1'b1};
                    o.res   = RW'(narrow);
                    o.oflow = ~|a;
                end
                A_INC_B: begin
                    narrow  = b + {{(WIDTH-1){1'b0}}, 1'b1};
                    o.res   = RW'(narrow);
                    o.oflow = &b;
                end
                A_DEC_B: begin
                    narrow  = b - {{(WIDTH-1){1'b0}}, 1'b1};
                    o.res   = RW'(narrow);
                    o.oflow = ~|b;
                end
                A_CMP: begin
                    o.e = (a == b);
                    o.g = (a > b);
                    o.l = (a < b);
                end
                A_MUL_INC, A_MUL_SHL: begin
                    o = '0;
                end
                default: begin
                    o.err = 1'b1;
                end
            endcase
        end else begin
            case (cmd)
                L_AND:    narrow = a & b;
                L_NAND:   narrow = ~(a & b);
                L_OR:     narrow = a | b;
                L_NOR:    narrow = ~(a | b);
                L_XOR:    narrow = a ^ b;
                L_XNOR:   narrow = ~(a ^ b);
                L_NOT_A:  narrow = ~a;
                L_NOT_B:  narrow = ~b;
                L_SHR1_A: narrow = a >> 1;
                L_SHL1_A: narrow = a << 1;
                L_SHR1_B: narrow = b >> 1;
                L_SHL1_B: narrow = b << 1;
                // Rotates shift a doubled copy of A; out-of-range amount
                // bits only raise ERR, the rotated value is still returned.
                L_ROL_A_B: begin
                    rot    = {a, a} << b[SH-1:0];
                    narrow = rot[RW-1:WIDTH];
                    o.err  = |(b >> SH);
                end
                L_ROR_A_B: begin
                    rot    = {a, a} >> b[SH-1:0];
                    narrow = rot[WIDTH-1:0];
                    o.err  = |(b >> SH);
                end
                default: begin
                    o.err = 1'b1;
                end
            endcase
            o.res = RW'(narrow);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  in_opa_r, in_opb_r;
    logic [CWIDTH-1:0] in_cmd_r;
    logic              in_mode_r, in_cin_r, in_ce_r;
    logic [1:0]        in_valid_r;

    state_t            state_r, state_s;
    logic [CWIDTH-1:0] cap_cmd_r, cap_cmd_s;
    logic              cap_mode_r, cap_mode_s;
    logic              cap_cin_r, cap_cin_s;
    logic [3:0]        cnt_r, cnt_s;
    logic [MW-1:0]     mul_a_r, mul_a_s, mul_b_r, mul_b_s;
    logic [RW-1:0]     prod_r, prod_s;
    out_t              out_r, out_s;

    logic [CWIDTH-1:0] exec_cmd_s;
    logic              exec_mode_s, exec_cin_s, exec_mul_s;
    logic [MW-1:0]     mul_opa_s, mul_opb_s;
    out_t              exec_out_s;
    logic [1:0]        need_s;
    logic              ok_s;

    // Input stage: capture the protocol inputs at every edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_opa_r   <= '0;
            in_opb_r   <= '0;
            in_cmd_r   <= '0;
            in_mode_r  <= 1'b0;
            in_cin_r   <= 1'b0;
            in_ce_r    <= 1'b0;
            in_valid_r <= 2'b00;
        end else begin
            in_opa_r   <= OPA;
            in_opb_r   <= OPB;
            in_cmd_r   <= CMD;
            in_mode_r  <= MODE;
            in_cin_r   <= CIN;
            in_ce_r    <= CE;
            in_valid_r <= INP_VALID;
        end
    end

    // Command source: the captured command while waiting for operands.
    always_comb begin
        exec_cmd_s  = in_cmd_r;
        exec_mode_s = in_mode_r;
        exec_cin_s  = in_cin_r;
        if (state_r == S_WAIT_OP) begin
            exec_cmd_s  = cap_cmd_r;
            exec_mode_s = cap_mode_r;
            exec_cin_s  = cap_cin_r;
        end else begin
            exec_cmd_s  = in_cmd_r;
            exec_mode_s = in_mode_r;
            exec_cin_s  = in_cin_r;
        end
    end

    assign exec_out_s = compute(exec_mode_s, exec_cmd_s, exec_cin_s, in_opa_r, in_opb_r);
    assign exec_mul_s = is_mul(exec_mode_s, exec_cmd_s);
    assign need_s     = need_mask(in_mode_r, in_cmd_r);
    assign ok_s       = cmd_ok(in_mode_r, in_cmd_r);

    // Multiplier operand preparation for MUL_INC and MUL_SHL.
    always_comb begin
        mul_opa_s = {in_opa_r, 1'b0};
        mul_opb_s = {1'b0, in_opb_r};
        if (exec_cmd_s == A_MUL_INC) begin
            mul_opa_s = {1'b0, in_opa_r} + {{WIDTH{1'b0}}, 1'b1};
            mul_opb_s = {1'b0, in_opb_r} + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            mul_opa_s = {in_opa_r, 1'b0};
            mul_opb_s = {1'b0, in_opb_r};
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        cap_cmd_s  = cap_cmd_r;
        cap_mode_s = cap_mode_r;
        cap_cin_s  = cap_cin_r;
        cnt_s      = cnt_r;
        mul_a_s    = mul_a_r;
        mul_b_s    = mul_b_r;
        prod_s     = prod_r;
        out_s      = out_r;
        if (!in_ce_r) begin
            state_s = S_IDLE;
            cnt_s   = 4'd0;
            out_s   = '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid_r == 2'b00) begin
                        out_s = '0;
                    end else if (!ok_s) begin
                        out_s = err_result();
                    end else if ((need_s & in_valid_r) == 2'b00) begin
                        out_s = err_result();
                    end else if ((need_s == 2'b11) && (in_valid_r != 2'b11)) begin
                        // One operand of a two-operand command: hold outputs
                        // and wait; the counter starts at the first wait edge.
                        cap_cmd_s  = in_cmd_r;
                        cap_mode_s = in_mode_r;
                        cap_cin_s  = in_cin_r;
                        cnt_s      = 4'd1;
                        state_s    = S_WAIT_OP;
                    end else if (exec_mul_s) begin
                        mul_a_s = mul_opa_s;
                        mul_b_s = mul_opb_s;
                        state_s = S_MUL1;
                    end else begin
                        out_s = exec_out_s;
                    end
                end
                S_WAIT_OP: begin
                    if (in_valid_r == 2'b11) begin
                        if (exec_mul_s) begin
                            mul_a_s = mul_opa_s;
                            mul_b_s = mul_opb_s;
                            state_s = S_MUL1;
                        end else begin
                            out_s   = exec_out_s;
                            state_s = S_IDLE;
                        end
                    end else if (cnt_r == 4'd15) begin
                        out_s   = err_result();
                        state_s = S_IDLE;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end
                S_MUL1: begin
                    // Product reduced modulo 2^(2*WIDTH).
                    prod_s  = RW'(mul_a_r * mul_b_r);
                    state_s = S_MUL2;
                end
                S_MUL2: begin
                    out_s     = '0;
                    out_s.res = prod_r;
                    state_s   = S_IDLE;
                end
                default: begin
                    out_s   = '0;
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State, pipeline and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= S_IDLE;
            cap_cmd_r  <= '0;
            cap_mode_r <= 1'b0;
            cap_cin_r  <= 1'b0;
            cnt_r      <= 4'd0;
            mul_a_r    <= '0;
            mul_b_r    <= '0;
            prod_r     <= '0;
            out_r      <= '0;
        end else begin
            state_r    <= state_s;
            cap_cmd_r  <= cap_cmd_s;
            cap_mode_r <= cap_mode_s;
            cap_cin_r  <= cap_cin_s;
            cnt_r      <= cnt_s;
            mul_a_r    <= mul_a_s;
            mul_b_r    <= mul_b_s;
            prod_r     <= prod_s;
            out_r      <= out_s;
        end
    end

    assign RES   = out_r.res;
    assign COUT  = out_r.cout;
    assign OFLOW = out_r.oflow;
    assign E     = out_r.e;
    assign G     = out_r.g;
    assign L     = out_r.l;
    assign ERR   = out_r.err;

endmodule

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_core
//   Directed, self-checking bench for alu_core (WIDTH=8, CWIDTH=4).
//   Inputs are driven 1 ns after a rising edge and outputs are sampled
//   1 ns after a rising edge. Expected values are hand-computed.
//   Flag vectors are written as {COUT, OFLOW, E, G, L, ERR}.
// ---------------------------------------------------------------------------
module tb_alu_core;

    logic        CLK;
    logic        RST;
    logic [7:0]  OPA;
    logic [7:0]  OPB;
    logic [3:0]  CMD;
    logic        MODE;
    logic        CIN;
    logic        CE;
    logic [1:0]  INP_VALID;
    logic [15:0] RES;
    logic        COUT;
    logic        OFLOW;
    logic        E;
    logic        G;
    logic        L;
    logic        ERR;

    int checks   = 0;
    int failures = 0;

    alu_core #(.WIDTH(8), .CWIDTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .OPA       (OPA),
        .OPB       (OPB),
        .CMD       (CMD),
        .MODE      (MODE),
        .CIN       (CIN),
        .CE        (CE),
        .INP_VALID (INP_VALID),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .E         (E),
        .G         (G),
        .L         (L),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance past one rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic mode, input logic [3:0] cmd,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] v, input logic cin);
        MODE      = mode;
        CMD       = cmd;
        OPA       = a;
        OPB       = b;
        INP_VALID = v;
        CIN       = cin;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp_res, input logic [5:0] exp_flags);
        logic [21:0] obs_v;
        logic [21:0] exp_v;
        obs_v = {RES, COUT, OFLOW, E, G, L, ERR};
        exp_v = {exp_res, exp_flags};
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed res=%h flags=%b expected res=%h flags=%b",
                   tag, obs_v[21:6], obs_v[5:0], exp_res, exp_flags);
        end
    endtask

    initial begin
        // Reset
        RST = 1'b1;
        CE  = 1'b0;
        drive(1'b0, 4'd0, 8'd0, 8'd0, 2'b00, 1'b0);
        step();
        step();
        chk("reset", 16'h0000, 6'b000000);
        RST = 1'b0;
        CE  = 1'b1;

        // Back-to-back single-cycle operations
        drive(1'b1, 4'd0, 8'd200, 8'd100, 2'b11, 1'b0);          // ADD
        step();
        drive(1'b1, 4'd1, 8'd9, 8'd4, 2'b11, 1'b0);              // SUB
        step();
        chk("add_200_100", 16'h012C, 6'b100000);
        drive(1'b1, 4'd3, 8'd4, 8'd9, 2'b11, 1'b1);              // SUB_CIN borrow
        step();
        chk("sub_9_4", 16'h0005, 6'b000000);
        drive(1'b1, 4'd4, 8'hFF, 8'h00, 2'b01, 1'b0);            // INC_A wrap
        step();
        chk("sub_cin_borrow", 16'h00FA, 6'b110000);
        drive(1'b1, 4'd7, 8'h12, 8'h00, 2'b10, 1'b0);            // DEC_B wrap
        step();
        chk("inc_a_wrap", 16'h0000, 6'b010000);
        drive(1'b1, 4'd2, 8'hFF, 8'hFF, 2'b11, 1'b1);            // ADD_CIN max
        step();
        chk("dec_b_wrap", 16'h00FF, 6'b010000);
        drive(1'b0, 4'd4, 8'hF0, 8'h3C, 2'b11, 1'b0);            // XOR
        step();
        chk("add_cin_max", 16'h01FF, 6'b100000);
        drive(1'b0, 4'd1, 8'hF0, 8'h3C, 2'b11, 1'b0);            // NAND
        step();
        chk("xor", 16'h00CC, 6'b000000);
        drive(1'b1, 4'd6, 8'h10, 8'h20, 2'b01, 1'b0);            // INC_B without B
        step();
        chk("nand", 16'h00CF, 6'b000000);
        drive(1'b1, 4'd0, 8'd0, 8'd0, 2'b00, 1'b0);
        step();
        chk("inc_b_missing_op", 16'h0000, 6'b000001);
        step();
        chk("valid_00_clear", 16'h0000, 6'b000000);

        // Multiply pipeline, inputs ignored while busy
        drive(1'b1, 4'd0, 8'd1, 8'd2, 2'b11, 1'b0);              // ADD 1+2
        step();
        drive(1'b1, 4'd9, 8'd3, 8'd4, 2'b11, 1'b0);              // MUL_INC
        step();
        chk("add_before_mul", 16'h0003, 6'b000000);
        drive(1'b1, 4'd0, 8'd50, 8'd50, 2'b11, 1'b0);            // ignored
        step();
        chk("mul_hold_k1", 16'h0003, 6'b000000);
        step();
        chk("mul_hold_k2", 16'h0003, 6'b000000);
        INP_VALID = 2'b00;
        step();
        chk("mul_inc_k3", 16'h0014, 6'b000000);
        drive(1'b1, 4'd10, 8'd5, 8'd7, 2'b11, 1'b0);             // MUL_SHL
        step();
        INP_VALID = 2'b00;
        step();
        step();
        step();
        chk("mul_shl_k3", 16'h0046, 6'b000000);

        // Operand wait that times out
        drive(1'b1, 4'd1, 8'd7, 8'd0, 2'b01, 1'b0);
        step();
        INP_VALID = 2'b00;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        chk("wait_hold_k15", 16'h0000, 6'b000000);
        step();
        chk("wait_timeout_k16", 16'h0000, 6'b000001);

        // Operand wait completed at k+5; MODE/CMD changes ignored
        drive(1'b1, 4'd1, 8'd0, 8'd0, 2'b01, 1'b0);
        step();
        INP_VALID = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        drive(1'b0, 4'd0, 8'd9, 8'd4, 2'b11, 1'b0);
        step();
        chk("wait_hold_k5", 16'h0000, 6'b000000);
        step();
        chk("wait_sub_k6", 16'h0005, 6'b000000);

        // Operand wait completed on its last edge, k+15
        drive(1'b1, 4'd0, 8'd0, 8'd20, 2'b10, 1'b0);
        step();
        INP_VALID = 2'b00;
        for (int i = 0; i < 14; i++) begin
            step();
        end
        drive(1'b1, 4'd5, 8'd10, 8'd20, 2'b11, 1'b0);
        step();
        chk("wait_last_hold", 16'h0000, 6'b000000);
        step();
        chk("wait_last_add", 16'h001E, 6'b000000);

        // Rotates
        drive(1'b0, 4'd12, 8'h81, 8'h01, 2'b11, 1'b0);
        step();
        drive(1'b0, 4'd12, 8'h81, 8'hF1, 2'b11, 1'b0);
        step();
        chk("rol_by_1", 16'h0003, 6'b000000);
        drive(1'b0, 4'd13, 8'h81, 8'h01, 2'b11, 1'b0);
        step();
        chk("rol_high_bits_err", 16'h0003, 6'b000001);
        INP_VALID = 2'b00;
        step();
        chk("ror_by_1", 16'h00C0, 6'b000000);

        // Compare, then a CE=0 edge
        drive(1'b1, 4'd8, 8'h55, 8'h55, 2'b11, 1'b0);
        step();
        drive(1'b1, 4'd8, 8'h20, 8'h10, 2'b11, 1'b0);
        step();
        chk("cmp_equal", 16'h0000, 6'b001000);
        drive(1'b1, 4'd8, 8'h10, 8'h20, 2'b11, 1'b0);
        step();
        chk("cmp_greater", 16'h0000, 6'b000100);
        drive(1'b1, 4'd0, 8'd1, 8'd1, 2'b11, 1'b0);
        CE = 1'b0;
        step();
        chk("cmp_less", 16'h0000, 6'b000010);
        CE = 1'b1;
        step();
        chk("ce_low_clear", 16'h0000, 6'b000000);
        step();
        chk("after_ce_add", 16'h0002, 6'b000000);

        // Reset during MUL1 aborts the multiply
        drive(1'b1, 4'd9, 8'd3, 8'd4, 2'b11, 1'b0);
        step();
        RST       = 1'b1;
        INP_VALID = 2'b00;
        step();
        chk("rst_in_mul1", 16'h0000, 6'b000000);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_late_mul", 16'h0000, 6'b000000);
        end

        // Invalid arithmetic command
        drive(1'b1, 4'd14, 8'd1, 8'd2, 2'b11, 1'b0);
        step();
        INP_VALID = 2'b00;
        step();
        chk("invalid_cmd14", 16'h0000, 6'b000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
